// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC FIR controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package anc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    // Raw LMS step before saturation: arithmetic shift on 16 bits, optional
    // negation in 17 bits so that -(-32768) is representable.
    function automatic logic signed [16:0] lms_step(
        input logic signed [15:0] e,
        input logic [3:0]         sh,
        input logic               neg
    );
        logic signed [15:0] shifted;
        logic signed [16:0] ext;
        shifted = e >>> sh;
        ext     = {shifted[15], shifted};
        return neg ? -ext : ext;
    endfunction

endpackage

// File: rtl/saturate.sv
// Signed saturation from IW bits down to OW bits.
// Latency: combinational.
// Backpressure: n/a.
module saturate #(
    parameter int IW = 17,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] in_i,
    output logic signed [OW-1:0] out_o
);

    localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Clamp to the representable OW-bit range, otherwise pass the low bits.
    always_comb begin
        if (in_i > MAXV) begin
            out_o = MAXV[OW-1:0];
        end else if (in_i < MINV) begin
            out_o = MINV[OW-1:0];
        end else begin
            out_o = in_i[OW-1:0];
        end
    end

endmodule

// File: rtl/anc_fir_ctrl.sv
// Pairs x/e samples, computes the LMS step, kicks the FIR and forwards its result.
// Latency: fir_go 2 cycles after the later strobe; y_valid 1 cycle after fir_done.
// Backpressure: y_valid held until y_ready; an unaccepted result is overwritten (y_drop).
module anc_fir_ctrl
    import anc_pkg::*;
#(
    parameter int TAPS    = 256,
    parameter int TIMEOUT = 512,
    parameter int TW      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] x_sample,
    input  logic        x_valid,
    input  logic [15:0] err_sample,
    input  logic        err_valid,
    input  logic [3:0]  mu_shift,
    input  logic        mu_neg,
    input  logic [15:0] bias,
    input  logic        clr_status,
    output logic [15:0] fir_x_in,
    output logic [15:0] fir_a_in,
    output logic [15:0] fir_weight_adjust,
    output logic        fir_go,
    input  logic [15:0] fir_out_sample,
    input  logic        fir_done,
    output logic [15:0] y_sample,
    output logic        y_valid,
    input  logic        y_ready,
    output logic        busy,
    output logic        overrun,
    output logic        timeout,
    output logic        y_drop
);

    // The watchdog must outlast a normal FIR run and fit in the counter.
    if (TIMEOUT <= TAPS + 7) begin : g_bad_timeout
        $error("anc_fir_ctrl: TIMEOUT must exceed TAPS+7");
    end
    if ((64'd1 << TW) <= 64'(TIMEOUT)) begin : g_bad_tw
        $error("anc_fir_ctrl: TW too narrow for TIMEOUT");
    end

    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] x_hold_q, x_hold_d;
    logic [15:0] e_hold_q, e_hold_d;
    logic        x_got_q, x_got_d;
    logic        e_got_q, e_got_d;
    logic [15:0] fir_x_q, fir_x_d;
    logic [15:0] fir_a_q, fir_a_d;
    logic [15:0] fir_adj_q, fir_adj_d;
    logic        fir_go_q, fir_go_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [15:0] y_sample_q, y_sample_d;
    logic        y_valid_q, y_valid_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic        y_drop_q, y_drop_d;

    logic        issuing;
    logic        ovr_evt;
    logic        result_evt;
    logic        tmo_evt;
    logic        drop_evt;
    logic signed [16:0] step_raw;
    logic signed [15:0] step_sat;

    assign step_raw = lms_step(e_hold_q, mu_shift, mu_neg);

    saturate #(.IW(17), .OW(16)) u_sat (
        .in_i  (step_raw),
        .out_o (step_sat)
    );

    // Sample capture: one pending pair; a repeat strobe overwrites and flags overrun,
    // except while the pair is being consumed in ISSUE.
    always_comb begin
        issuing  = (state_q == ISSUE);
        x_hold_d = x_valid   ? x_sample   : x_hold_q;
        e_hold_d = err_valid ? err_sample : e_hold_q;
        x_got_d  = x_got_q;
        e_got_d  = e_got_q;
        if (issuing) begin
            x_got_d = 1'b0;
            e_got_d = 1'b0;
        end
        if (x_valid) begin
            x_got_d = 1'b1;
        end
        if (err_valid) begin
            e_got_d = 1'b1;
        end
        ovr_evt = !issuing && ((x_valid && x_got_q) || (err_valid && e_got_q));
    end

    // Sequencer: wait for a pair, latch FIR operands, then wait for done or the watchdog.
    always_comb begin
        state_d    = state_q;
        fir_x_d    = fir_x_q;
        fir_a_d    = fir_a_q;
        fir_adj_d  = fir_adj_q;
        fir_go_d   = 1'b0;
        tcnt_d     = tcnt_q;
        result_evt = 1'b0;
        tmo_evt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (x_got_q && e_got_q) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fir_x_d   = x_hold_q;
                fir_a_d   = bias;
                fir_adj_d = step_sat;
                fir_go_d  = 1'b1;
                tcnt_d    = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (fir_done) begin
                    result_evt = 1'b1;
                    tcnt_d     = '0;
                    state_d    = IDLE;
                end else if (tcnt_q == TCNT_LAST) begin
                    tmo_evt = 1'b1;
                    tcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register and sticky status; a same-cycle event beats clr_status.
    always_comb begin
        y_sample_d = y_sample_q;
        y_valid_d  = y_valid_q;
        drop_evt   = 1'b0;
        if (result_evt) begin
            y_sample_d = fir_out_sample;
            y_valid_d  = 1'b1;
            drop_evt   = y_valid_q && !y_ready;
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
        overrun_d = ovr_evt  || (overrun_q && !clr_status);
        timeout_d = tmo_evt  || (timeout_q && !clr_status);
        y_drop_d  = drop_evt || (y_drop_q  && !clr_status);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_hold_q   <= '0;
            e_hold_q   <= '0;
            x_got_q    <= 1'b0;
            e_got_q    <= 1'b0;
            fir_x_q    <= '0;
            fir_a_q    <= '0;
            fir_adj_q  <= '0;
            fir_go_q   <= 1'b0;
            tcnt_q     <= '0;
            y_sample_q <= '0;
            y_valid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            y_drop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_hold_q   <= x_hold_d;
            e_hold_q   <= e_hold_d;
            x_got_q    <= x_got_d;
            e_got_q    <= e_got_d;
            fir_x_q    <= fir_x_d;
            fir_a_q    <= fir_a_d;
            fir_adj_q  <= fir_adj_d;
            fir_go_q   <= fir_go_d;
            tcnt_q     <= tcnt_d;
            y_sample_q <= y_sample_d;
            y_valid_q  <= y_valid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            y_drop_q   <= y_drop_d;
        end
    end

    assign fir_x_in          = fir_x_q;
    assign fir_a_in          = fir_a_q;
    assign fir_weight_adjust = fir_adj_q;
    assign fir_go            = fir_go_q;
    assign y_sample          = y_sample_q;
    assign y_valid           = y_valid_q;
    assign busy              = (state_q != IDLE);
    assign overrun           = overrun_q;
    assign timeout           = timeout_q;
    assign y_drop            = y_drop_q;

endmodule

// File: tb/tb_anc_fir_ctrl.sv
// Directed bench for anc_fir_ctrl with a behavioural FIR stub.
// Latency: stub raises fir_done TAPS+7 cycles after fir_go.
// Backpressure: y_ready driven by the stimulus.
module tb_anc_fir_ctrl;

    localparam int TAPS    = 256;
    localparam int TIMEOUT = 512;
    localparam int TW      = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] x_sample = '0;
    logic        x_valid = 1'b0;
    logic [15:0] err_sample = '0;
    logic        err_valid = 1'b0;
    logic [3:0]  mu_shift = '0;
    logic        mu_neg = 1'b0;
    logic [15:0] bias = '0;
    logic        clr_status = 1'b0;
    logic [15:0] fir_x_in;
    logic [15:0] fir_a_in;
    logic [15:0] fir_weight_adjust;
    logic        fir_go;
    logic [15:0] fir_out_sample = '0;
    logic        fir_done = 1'b0;
    logic [15:0] y_sample;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic        busy;
    logic        overrun;
    logic        timeout;
    logic        y_drop;

    logic        stub_en = 1'b1;
    logic [15:0] stub_val = '0;

    int errors = 0;
    int checks = 0;

    anc_fir_ctrl #(.TAPS(TAPS), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .x_sample          (x_sample),
        .x_valid           (x_valid),
        .err_sample        (err_sample),
        .err_valid         (err_valid),
        .mu_shift          (mu_shift),
        .mu_neg            (mu_neg),
        .bias              (bias),
        .clr_status        (clr_status),
        .fir_x_in          (fir_x_in),
        .fir_a_in          (fir_a_in),
        .fir_weight_adjust (fir_weight_adjust),
        .fir_go            (fir_go),
        .fir_out_sample    (fir_out_sample),
        .fir_done          (fir_done),
        .y_sample          (y_sample),
        .y_valid           (y_valid),
        .y_ready           (y_ready),
        .busy              (busy),
        .overrun           (overrun),
        .timeout           (timeout),
        .y_drop            (y_drop)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // FIR stub: done pulse carrying stub_val, TAPS+7 cycles after fir_go.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fir_go) begin
                repeat (TAPS + 7) @(posedge clk);
                #1;
                if (stub_en && rst_n) begin
                    fir_out_sample = stub_val;
                    fir_done       = 1'b1;
                    @(posedge clk);
                    #1;
                    fir_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] x;
        logic [15:0] e;
        logic [3:0]  sh;
        logic        neg;
        logic [15:0] b;
        logic [15:0] yval;
        logic [15:0] exp_adj;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe x and/or e now (called just after a rising edge), then check fir_go timing
    // and the latched operands. Returns at the falling edge of the fir_go cycle.
    task automatic issue_pair(input logic do_x, input logic do_e,
                              input logic [15:0] x, input logic [15:0] e,
                              input logic [3:0] sh, input logic neg, input logic [15:0] b,
                              input logic [15:0] exp_x, input logic [15:0] exp_adj,
                              input string tag);
        mu_shift   = sh;
        mu_neg     = neg;
        bias       = b;
        x_sample   = x;
        err_sample = e;
        x_valid    = do_x;
        err_valid  = do_e;
        step();
        x_valid   = 1'b0;
        err_valid = 1'b0;
        @(negedge clk);
        check({tag, "_busy_e0"}, {15'd0, busy}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_go_e1"}, {15'd0, fir_go}, 16'd0);
        check({tag, "_busy_e1"}, {15'd0, busy}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_go_e2"}, {15'd0, fir_go}, 16'd1);
        check({tag, "_x_in"}, fir_x_in, exp_x);
        check({tag, "_a_in"}, fir_a_in, b);
        check({tag, "_adjust"}, fir_weight_adjust, exp_adj);
    endtask

    // Count falling edges from the fir_go cycle until y_valid rises (bounded).
    task automatic wait_y(output int n);
        n = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            n = i;
            if (y_valid) break;
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{x:16'h4000, e:16'h2000, sh:4'd2,  neg:1'b1, b:16'h0100, yval:16'h1234, exp_adj:16'hF800};
        vecs[1] = '{x:16'h7FFF, e:16'h8000, sh:4'd0,  neg:1'b1, b:16'h0000, yval:16'h5A5A, exp_adj:16'h7FFF};
        vecs[2] = '{x:16'h8000, e:16'h8000, sh:4'd0,  neg:1'b0, b:16'hFFFF, yval:16'hA5A5, exp_adj:16'h8000};
        vecs[3] = '{x:16'h0001, e:16'h8000, sh:4'd15, neg:1'b0, b:16'h1000, yval:16'h0001, exp_adj:16'hFFFF};
        vecs[4] = '{x:16'h1357, e:16'h8000, sh:4'd15, neg:1'b1, b:16'h2000, yval:16'h8000, exp_adj:16'h0001};
        vecs[5] = '{x:16'hC000, e:16'h7FFF, sh:4'd4,  neg:1'b1, b:16'h7FFF, yval:16'h7FFF, exp_adj:16'hF801};
        vecs[6] = '{x:16'h0F0F, e:16'h1234, sh:4'd1,  neg:1'b0, b:16'h8000, yval:16'h0F0F, exp_adj:16'h091A};
        vecs[7] = '{x:16'h2468, e:16'hF000, sh:4'd3,  neg:1'b1, b:16'h4321, yval:16'hBEEF, exp_adj:16'h0200};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x_in", fir_x_in, 16'd0);
        check("rst_a_in", fir_a_in, 16'd0);
        check("rst_adjust", fir_weight_adjust, 16'd0);
        check("rst_go", {15'd0, fir_go}, 16'd0);
        check("rst_y_sample", y_sample, 16'd0);
        check("rst_flags", {10'd0, y_valid, busy, overrun, timeout, y_drop, 1'b0}, 16'd0);
        step();
        rst_n = 1'b1;
        step();

        // Table of paired samples, y_ready held high.
        y_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            stub_val = vecs[k].yval;
            issue_pair(1'b1, 1'b1, vecs[k].x, vecs[k].e, vecs[k].sh, vecs[k].neg, vecs[k].b,
                       vecs[k].x, vecs[k].exp_adj, $sformatf("vec%0d", k));
            wait_y(n);
            check($sformatf("vec%0d_y_latency", k), 16'(n), 16'(TAPS + 8));
            check($sformatf("vec%0d_y_sample", k), y_sample, vecs[k].yval);
            @(negedge clk);
            check($sformatf("vec%0d_y_valid_clr", k), {15'd0, y_valid}, 16'd0);
            check($sformatf("vec%0d_busy_end", k), {15'd0, busy}, 16'd0);
            check($sformatf("vec%0d_flags", k), {13'd0, overrun, timeout, y_drop}, 16'd0);
            step();
        end

        // Overrun: two x strobes before e; the second x is issued.
        x_sample = 16'h1111;
        x_valid  = 1'b1;
        step();
        x_sample = 16'h2222;
        step();
        x_valid = 1'b0;
        @(negedge clk);
        check("ovr_set", {15'd0, overrun}, 16'd1);
        check("ovr_busy", {15'd0, busy}, 16'd0);
        step();
        stub_val = 16'h0BEE;
        issue_pair(1'b0, 1'b1, 16'h0000, 16'h0100, 4'd0, 1'b0, 16'h0000,
                   16'h2222, 16'h0100, "ovr");
        wait_y(n);
        check("ovr_y_sample", y_sample, 16'h0BEE);
        check("ovr_still_set", {15'd0, overrun}, 16'd1);
        step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        @(negedge clk);
        check("ovr_cleared", {15'd0, overrun}, 16'd0);
        step();

        // Timeout: FIR never answers.
        stub_en = 1'b0;
        issue_pair(1'b1, 1'b1, 16'h0AAA, 16'h0400, 4'd2, 1'b0, 16'h0001,
                   16'h0AAA, 16'h0100, "tmo");
        n = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            n = i;
            if (!busy) break;
        end
        check("tmo_cycles", 16'(n), 16'(TIMEOUT));
        check("tmo_flag", {15'd0, timeout}, 16'd1);
        check("tmo_no_y", {15'd0, y_valid}, 16'd0);
        step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        @(negedge clk);
        check("tmo_cleared", {15'd0, timeout}, 16'd0);
        stub_en = 1'b1;
        step();

        // Backpressure: two results without y_ready.
        y_ready  = 1'b0;
        stub_val = 16'h1111;
        issue_pair(1'b1, 1'b1, 16'h0100, 16'h0200, 4'd1, 1'b0, 16'h0000,
                   16'h0100, 16'h0100, "bp1");
        wait_y(n);
        check("bp1_y_sample", y_sample, 16'h1111);
        check("bp1_no_drop", {15'd0, y_drop}, 16'd0);
        step();
        stub_val = 16'h2222;
        issue_pair(1'b1, 1'b1, 16'h0300, 16'h0400, 4'd1, 1'b1, 16'h0000,
                   16'h0300, 16'hFE00, "bp2");
        repeat (TAPS + 7) @(negedge clk);
        check("bp2_held_sample", y_sample, 16'h1111);
        check("bp2_pre_drop", {15'd0, y_drop}, 16'd0);
        @(negedge clk);
        check("bp2_y_sample", y_sample, 16'h2222);
        check("bp2_y_valid", {15'd0, y_valid}, 16'd1);
        check("bp2_drop", {15'd0, y_drop}, 16'd1);
        step();
        y_ready = 1'b1;
        @(negedge clk);
        check("bp2_wait_accept", {15'd0, y_valid}, 16'd1);
        @(negedge clk);
        check("bp2_accepted", {15'd0, y_valid}, 16'd0);
        check("bp2_drop_sticky", {15'd0, y_drop}, 16'd1);
        step();

        // Asynchronous reset while waiting on the FIR.
        stub_val = 16'h7777;
        issue_pair(1'b1, 1'b1, 16'h5555, 16'h1000, 4'd0, 1'b0, 16'h0042,
                   16'h5555, 16'h1000, "mid");
        repeat (10) @(negedge clk);
        stub_en = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("mid_x_in", fir_x_in, 16'd0);
        check("mid_a_in", fir_a_in, 16'd0);
        check("mid_adjust", fir_weight_adjust, 16'd0);
        check("mid_y_sample", y_sample, 16'd0);
        check("mid_flags", {10'd0, fir_go, y_valid, busy, overrun, timeout, y_drop}, 16'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("post_rst_idle", {14'd0, busy, y_valid}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
